// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - request, shared-adder and response bundle for fp_add_arbiter
// The slave modport is the arbiter's side. The master modport is the requester/adder environment.
interface fp_add_arbiter_if #(
  parameter int N  = 4,
  parameter int WA = 9,
  parameter int WB = 9,
  parameter int WS = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // requester side
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic [N-1:0]    req_sign;

  // shared adder side
  logic [WA-1:0]   add_a;
  logic [WB-1:0]   add_b;
  logic            add_sign;
  logic [WS-1:0]   add_sum;
  logic            add_ovf;
  logic            add_unf;

  // response side
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [WS-1:0]   rsp_sum;
  logic            rsp_ovf;
  logic            rsp_unf;
  logic [7:0]      err_cnt;

  modport slave (
    input  req_valid, req_a, req_b, req_sign, add_sum, add_ovf, add_unf,
    output req_ready, add_a, add_b, add_sign,
    output rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf, err_cnt
  );

  modport master (
    output req_valid, req_a, req_b, req_sign, add_sum, add_ovf, add_unf,
    input  req_ready, add_a, add_b, add_sign,
    input  rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf, err_cnt
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one fixed-point adder; FP_ARB_ERRCNT_EN enables err_cnt
// Grants one requester per cycle, registers its operands onto the adder and
// carries the grant id through a tag pipeline that matches the adder latency.
// Handshake at edge E0 -> add_* valid in C1 -> sum in C1+ADD_LAT -> rsp_valid
// in C2+ADD_LAT. Define FP_ARB_ERRCNT_EN to build the saturating error counter.
module fp_add_arbiter #(
  parameter int N       = 4,
  parameter int WA      = 9,
  parameter int WB      = 9,
  parameter int WS      = 8,
  parameter int ADD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_add_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] ptr;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic          hs;

  // tag[k] is valid k+1 cycles after the handshake; tag[ADD_LAT] lines up with add_sum
  logic [ADD_LAT:0] tag_vld;
  logic [IW-1:0]    tag_id [ADD_LAT+1];

  // Round-robin search starting at ptr, wrapping modulo N; first valid requester wins
  always_comb begin : p_grant
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_any && bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
  end

  // No handshake is offered while the block is held in reset
  assign hs = gnt_any & rst_n;

  // One-hot ready for the granted requester only
  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Pointer moves just past the winner so every requester gets its turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Register the winner's operands onto the shared adder; hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_a    <= '0;
      bus.add_b    <= '0;
      bus.add_sign <= 1'b1;
    end else if (hs) begin
      bus.add_a    <= bus.req_a[gnt_idx*WA +: WA];
      bus.add_b    <= bus.req_b[gnt_idx*WB +: WB];
      bus.add_sign <= bus.req_sign[gnt_idx];
    end
  end

  // Tag pipeline shifts every cycle; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k <= ADD_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[ADD_LAT-1:0], hs};
      tag_id[0] <= gnt_idx;
      for (int k = 1; k <= ADD_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // Capture the adder result when its tag reaches the end; rsp_valid is a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_unf   <= 1'b0;
    end else begin
      bus.rsp_valid <= tag_vld[ADD_LAT];
      if (tag_vld[ADD_LAT]) begin
        bus.rsp_id  <= tag_id[ADD_LAT];
        bus.rsp_sum <= bus.add_sum;
        bus.rsp_ovf <= bus.add_ovf;
        bus.rsp_unf <= bus.add_unf;
      end
    end
  end

`ifdef FP_ARB_ERRCNT_EN
  logic [7:0] err_q;

  // Count responses flagged overflow or underflow, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (bus.rsp_valid && (bus.rsp_ovf || bus.rsp_unf) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule
